// File: rtl/pc_seq_pkg.sv
// Shared opcode map, instruction field widths and sequencer state encoding.
package pc_seq_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned OPND_W  = 8;
  localparam int unsigned INSTR_W = OPC_W + OPND_W;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_JMP  = 4'h8;
  localparam opcode_t OP_JZ   = 4'h9;
  localparam opcode_t OP_JC   = 4'hA;
  localparam opcode_t OP_CALL = 4'hB;
  localparam opcode_t OP_RET  = 4'hC;
  localparam opcode_t OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // Anything that is not a control-flow or halt opcode goes to the datapath.
  function automatic logic is_alu(input opcode_t op);
    return !((op == OP_JMP) || (op == OP_JZ) || (op == OP_JC) ||
             (op == OP_CALL) || (op == OP_RET) || (op == OP_HLT));
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits, occupancy counter as pointer.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign top     = mem[IDX_W'(cnt - CNT_W'(1))];

  // Occupancy counter; push has priority only nominally, the sequencer never issues both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_W'(1);
    end else if (do_pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[IDX_W'(cnt)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer: PC, PC+1, jump-target select, return stack and fetch handshake.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       STACK_D   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ir_load,
  output logic               exec_en,
  output logic               jmp_sel,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic               halted,
  output logic               stack_err
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  opcode_t           opc_q;
  logic [ADDR_W-1:0] target_q;
  logic              take_q;

  logic [ADDR_W-1:0] pc_inc_c;
  logic              take_c;
  logic              err_c;
  logic              push_c;
  logic              pop_c;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;

  assign imem_addr = pc;
  assign pc_inc_c  = pc + ADDR_W'(1);

  // IR strobe coincides with the accepted ack; imem_req is only high in FETCH.
  assign ir_load = imem_req && imem_ack;

  assign take_c = (opc_q == OP_JMP) ||
                  ((opc_q == OP_JZ) && flag_z) ||
                  ((opc_q == OP_JC) && flag_c) ||
                  (opc_q == OP_CALL) ||
                  (opc_q == OP_RET);

  assign err_c  = ((opc_q == OP_CALL) && stk_full) ||
                  ((opc_q == OP_RET) && stk_empty);

  // Stack errors divert to HALT from DECODE, so EXEC only sees legal push/pop.
  assign push_c = (state == ST_EXEC) && (opc_q == OP_CALL);
  assign pop_c  = (state == ST_EXEC) && (opc_q == OP_RET);

  ret_stack #(
    .DEPTH (STACK_D),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (pc_inc_c),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Sequencer FSM with PC update and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_VEC;
      opc_q     <= '0;
      target_q  <= '0;
      take_q    <= 1'b0;
      imem_req  <= 1'b0;
      exec_en   <= 1'b0;
      jmp_sel   <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      exec_en <= 1'b0;
      jmp_sel <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (imem_req && imem_ack) begin
            opc_q    <= imem_data[INSTR_W-1:OPND_W];
            target_q <= ADDR_W'(imem_data[OPND_W-1:0]);
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (err_c) begin
            stack_err <= 1'b1;
            halted    <= 1'b1;
            state     <= ST_HALT;
          end else begin
            exec_en <= is_alu(opc_q);
            jmp_sel <= take_c;
            take_q  <= take_c;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (opc_q == OP_HLT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (opc_q == OP_RET) begin
              pc <= stk_top;
            end else if (take_q) begin
              pc <= target_q;
            end else begin
              pc <= pc_inc_c;
            end
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a wait-state imem responder.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [11:0] imem_data = '0;
  logic        ir_load;
  logic        exec_en;
  logic        jmp_sel;
  logic        flag_z = 1'b0;
  logic        flag_c = 1'b0;
  logic        halted;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [256];
  int          wait_n = 0;
  int          wcnt = 0;

  logic [7:0]  fa [$];
  int          fc [$];
  int          fr [$];
  int          exec_cnt = 0;
  int          overlap = 0;
  int          cyc = 0;
  int          req_run = 0;
  logic        jsel_seen = 1'b0;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir_load   (ir_load),
    .exec_en   (exec_en),
    .jmp_sel   (jmp_sel),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after wait_n idle request cycles.
  always @(posedge clk) begin
    #1;
    if (imem_req) begin
      if (wcnt >= wait_n) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt      = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt     = wcnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // Monitor: log fetches, request lengths and strobes.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (imem_req) req_run = req_run + 1;
      if (ir_load) begin
        fa.push_back(imem_addr);
        fc.push_back(cyc);
        fr.push_back(req_run);
        req_run = 0;
      end
      if (exec_en) exec_cnt = exec_cnt + 1;
      if (ir_load && exec_en) overlap = overlap + 1;
      if (jmp_sel) jsel_seen = 1'b1;
    end
  end

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 12'h100;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fa.delete(); fc.delete(); fr.delete();
    exec_cnt = 0; req_run = 0; jsel_seen = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_fetches(input int n);
    int b = 0;
    while (fa.size() < n && b < 300) begin
      @(negedge clk); #1;
      b++;
    end
    checks++;
    if (fa.size() < n) begin
      errors++;
      $display("FAIL fetch_timeout: got %0d fetches, expected %0d", fa.size(), n);
    end
  endtask

  task automatic wait_halted();
    int b = 0;
    while (!halted && b < 300) begin
      @(negedge clk); #1;
      b++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_timeout: halted=%b expected 1", halted);
    end
  endtask

  task automatic test_reset();
    load_default();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, ir_load, exec_en, jmp_sel, halted, stack_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {imem_req, ir_load, exec_en, jmp_sel, halted, stack_err});
    end
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 00", imem_addr);
    end
  endtask

  task automatic test_alu_seq();
    load_default();
    wait_n = 0;
    do_reset();
    run_fetches(3);
    if (fa.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fa[i] !== 8'(i)) begin
          errors++;
          $display("FAIL alu_addr[%0d]: got %h expected %h", i, fa[i], 8'(i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fc[i] - fc[i-1] !== 3) begin
          errors++;
          $display("FAIL alu_cycles[%0d]: got %0d expected 3", i, fc[i] - fc[i-1]);
        end
      end
      checks++;
      if (exec_cnt !== 2) begin
        errors++;
        $display("FAIL alu_exec_cnt: got %0d expected 2", exec_cnt);
      end
    end
  endtask

  task automatic test_wait_states();
    load_default();
    wait_n = 2;
    do_reset();
    run_fetches(2);
    if (fa.size() >= 2) begin
      checks++;
      if (fr[1] !== 3) begin
        errors++;
        $display("FAIL wait_req_len: got %0d expected 3", fr[1]);
      end
      checks++;
      if (fc[1] - fc[0] !== 5) begin
        errors++;
        $display("FAIL wait_cycles: got %0d expected 5", fc[1] - fc[0]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (imem_addr !== 8'h01 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_decode_pc: got addr %h req %b expected 01 0", imem_addr, imem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_addr !== 8'h01 || exec_en !== 1'b1) begin
      errors++;
      $display("FAIL wait_exec_pc: got addr %h exec %b expected 01 1", imem_addr, exec_en);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_addr !== 8'h02 || imem_req !== 1'b1 || fa.size() !== 2) begin
      errors++;
      $display("FAIL wait_next_fetch: got addr %h req %b loads %0d expected 02 1 2",
               imem_addr, imem_req, fa.size());
    end
    wait_n = 0;
  endtask

  task automatic test_cond_jumps();
    load_default();
    mem[0] = 12'h940;
    flag_z = 1'b1;
    do_reset();
    run_fetches(2);
    checks++;
    if (fa.size() < 2 || fa[1] !== 8'h40 || jsel_seen !== 1'b1) begin
      errors++;
      $display("FAIL jz_taken: got addr %h jmp_sel %b expected 40 1",
               (fa.size() >= 2) ? fa[1] : 8'hxx, jsel_seen);
    end
    flag_z = 1'b0;
    do_reset();
    run_fetches(2);
    checks++;
    if (fa.size() < 2 || fa[1] !== 8'h01 || jsel_seen !== 1'b0) begin
      errors++;
      $display("FAIL jz_not_taken: got addr %h jmp_sel %b expected 01 0",
               (fa.size() >= 2) ? fa[1] : 8'hxx, jsel_seen);
    end
    mem[0] = 12'hA33;
    flag_c = 1'b1;
    do_reset();
    run_fetches(2);
    checks++;
    if (fa.size() < 2 || fa[1] !== 8'h33) begin
      errors++;
      $display("FAIL jc_taken: got addr %h expected 33", (fa.size() >= 2) ? fa[1] : 8'hxx);
    end
    flag_c = 1'b0;
  endtask

  task automatic test_call_ret();
    logic [7:0] exp [4];
    exp[0] = 8'h00; exp[1] = 8'h10; exp[2] = 8'h80; exp[3] = 8'h11;
    load_default();
    mem[8'h00] = 12'h810;
    mem[8'h10] = 12'hB80;
    mem[8'h80] = 12'hC00;
    do_reset();
    run_fetches(4);
    if (fa.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (fa[i] !== exp[i]) begin
          errors++;
          $display("FAIL call_ret_addr[%0d]: got %h expected %h", i, fa[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_stack_errors();
    load_default();
    for (int k = 0; k < 5; k++) mem[k] = 12'hB00 | 12'(k + 1);
    do_reset();
    wait_halted();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (stack_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || fa.size() !== 5) begin
      errors++;
      $display("FAIL call_overflow: got err %b halt %b req %b loads %0d expected 1 1 0 5",
               stack_err, halted, imem_req, fa.size());
    end
    load_default();
    mem[0] = 12'hC00;
    do_reset();
    checks++;
    if (stack_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b expected 0", stack_err);
    end
    wait_halted();
    checks++;
    if (stack_err !== 1'b1 || fa.size() !== 1 || exec_cnt !== 0) begin
      errors++;
      $display("FAIL ret_empty: got err %b loads %0d exec %0d expected 1 1 0",
               stack_err, fa.size(), exec_cnt);
    end
  endtask

  task automatic test_wrap();
    load_default();
    mem[0] = 12'h8FF;
    do_reset();
    run_fetches(3);
    checks++;
    if (fa.size() < 3 || fa[1] !== 8'hFF || fa[2] !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: got %h %h expected ff 00",
               (fa.size() >= 2) ? fa[1] : 8'hxx, (fa.size() >= 3) ? fa[2] : 8'hxx);
    end
  endtask

  task automatic test_hlt();
    load_default();
    mem[1] = 12'hF00;
    do_reset();
    wait_halted();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (stack_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h01 ||
        fa.size() !== 2 || exec_cnt !== 1) begin
      errors++;
      $display("FAIL hlt: got err %b req %b addr %h loads %0d exec %0d expected 0 0 01 2 1",
               stack_err, imem_req, imem_addr, fa.size(), exec_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int b = 0;
    load_default();
    mem[0] = 12'h805;
    wait_n = 0;
    do_reset();
    run_fetches(1);
    wait_n = 1000;
    while (!(imem_req === 1'b1 && imem_addr === 8'h05) && b < 20) begin
      @(negedge clk); #1;
      b++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL mid_fetch_pending: got req %b addr %h expected 1 05", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || ir_load !== 1'b0 || imem_addr !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_fetch_reset: got req %b load %b addr %h halt %b expected 0 0 00 0",
               imem_req, ir_load, imem_addr, halted);
    end
    wait_n = 0;
    do_reset();
    run_fetches(1);
    checks++;
    if (fa.size() < 1 || fa[0] !== 8'h00) begin
      errors++;
      $display("FAIL mid_fetch_refetch: got %h expected 00", (fa.size() >= 1) ? fa[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_wait_states();
    test_cond_jumps();
    test_call_ret();
    test_stack_errors();
    test_wrap();
    test_hlt();
    test_reset_mid_fetch();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d expected 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
